// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: tick prescaler, PWM period counter and a duty-cycle fade
// controller. A fade command ramps the duty one LSB at a time toward a target,
// moving only at PWM period boundaries so the PWM output never glitches.
module pwm_fade_ctrl #(
    parameter int R    = 8,
    parameter int bits = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [bits-1:0] final_value,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [R-1:0]    cmd_target,
    input  logic [7:0]      cmd_step_div,
    input  logic            abort,
    output logic            tick,
    output logic [R-1:0]    duty,
    output logic            period_end,
    output logic            busy,
    output logic            done
);

    localparam logic [R-1:0] MAX_VAL = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t          state;
    logic [bits-1:0] pre_cnt;
    logic [R-1:0]    pcnt;
    logic [7:0]      scnt;
    logic [R-1:0]    target;
    logic [7:0]      step_div;
    logic [R-1:0]    duty_next;

    // Strobes are decoded from the counters; rst_n keeps them low while the
    // block is held in reset even if enable is already high.
    assign tick       = rst_n & enable & (pre_cnt == final_value);
    assign period_end = tick & (pcnt == MAX_VAL);
    assign cmd_ready  = (state == IDLE);
    assign busy       = (state == RAMP);

    // Prescaler: wraps at final_value, or at once if final_value was lowered
    // below the current count (that wrap produces no tick).
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (enable) begin
            if (pre_cnt >= final_value) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // PWM period counter advances once per tick and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Next duty value: one LSB toward target, saturating at both ends.
    always_comb begin
        // NOTE: default assignment first so no path leaves duty_next
        // unassigned, which would otherwise infer a latch.
        duty_next = duty;
        if ((target > duty) && (duty != MAX_VAL)) begin
            duty_next = duty + 1'b1;
        end else if ((target < duty) && (duty != '0)) begin
            duty_next = duty - 1'b1;
        end
    end

    // Fade FSM: command acceptance, step pacing, abort and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            scnt     <= '0;
            duty     <= '0;
            target   <= '0;
            step_div <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is ignored here; a command always wins
                    if (cmd_valid) begin
                        target   <= cmd_target;
                        step_div <= cmd_step_div;
                        if (cmd_target != duty) begin
                            state <= RAMP;
                            scnt  <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    // abort has priority over a coincident step
                    if (abort) begin
                        state <= IDLE;
                    end else if (period_end) begin
                        if (scnt < step_div) begin
                            scnt <= scnt + 1'b1;
                        end else begin
                            scnt <= '0;
                            duty <= duty_next;
                            if (duty_next == target) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter: R, default 8, PWM resolution in bits; the PWM period is 2^R ticks and the duty width is R.
REQ-002 Parameter: bits, default 4, tick prescaler width.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: enable  in  1  run gate for the prescaler, period counter and ramp.
REQ-006 Port: final_value  in  bits  prescaler terminal count; the tick period is final_value+1 clk cycles.
REQ-007 Port: cmd_valid  in  1  new fade command offered.
REQ-008 Port: cmd_ready  out  1  controller can accept a command.
REQ-009 Port: cmd_target  in  R  target duty.
REQ-010 Port: cmd_step_div  in  8  number of PWM periods per duty step, minus 1.
REQ-011 Port: abort  in  1  stop the current ramp.
REQ-012 Port: tick  out  1  enable strobe for the PWM datapath.
REQ-013 Port: duty  out  R  current duty presented to the PWM.
REQ-014 Port: period_end  out  1  strobe on the last tick of each PWM period.
REQ-015 Port: busy  out  1  high while in RAMP.
REQ-016 Port: done  out  1  one-cycle pulse when duty reaches the target.

Function
REQ-017 Prescaler: counts 0..final_value while enable=1, and tick=1 in the cycle where count==final_value; with final_value=0, tick=1 every enabled cycle.
REQ-018 Period counter pcnt (R bits) increments on tick and wraps 2^R-1->0; period_end = tick & (pcnt==2^R-1).
REQ-019 With enable=0, the prescaler, pcnt and step counter hold their values, and tick=0 and period_end=0.
REQ-020 The state machine has two states, IDLE and RAMP; cmd_ready = (state==IDLE); busy = (state==RAMP).
REQ-021 In IDLE, when cmd_valid=1, the block latches target and step_div.
REQ-022 In IDLE, if a command has target != duty, the state becomes RAMP and the step counter scnt clears to 0.
REQ-023 In IDLE, if a command has target == duty, the state stays IDLE and done pulses in the next cycle.
REQ-024 In RAMP, on period_end: if scnt<step_div, scnt increments; otherwise scnt clears and duty moves by exactly 1 toward target.
REQ-025 When the stepped duty equals target, the state moves to IDLE in the same edge, and done=1 for the following cycle.
REQ-026 duty changes only on a period_end edge (glitch-free PWM), except at reset.
REQ-027 abort=1 in RAMP moves the state to IDLE at the next edge; duty freezes at its current value and done is not pulsed.
REQ-028 abort and period_end in the same RAMP cycle: abort wins, and no duty step occurs.
REQ-029 abort in IDLE is ignored; abort together with cmd_valid in IDLE is resolved as the command being accepted.
REQ-030 cmd_valid while in RAMP is not accepted (cmd_ready=0), and the ramp is unaffected.
REQ-031 Duty arithmetic saturates: it never wraps past 0 or 2^R-1.
REQ-032 A change to final_value mid-count takes effect at the next prescaler wrap; if count>final_value, the counter wraps to 0 on the next enabled cycle, with no tick.

Reset
REQ-033 While rst_n=0, the block asynchronously forces: state=IDLE, prescaler=0, pcnt=0, scnt=0, duty=0, target=0, step_div=0.
REQ-034 Outputs during and after reset: tick=0, period_end=0, done=0, busy=0, cmd_ready=1.
REQ-035 Reset asserted mid-ramp abandons the ramp with no done pulse; operation resumes from the all-zero state.

Verification (R=4, bits=4 unless stated)
REQ-036 Scenario tick rate: final_value=2, enable=1 -> tick every 3rd cycle; period_end every 48 cycles.
REQ-037 Scenario ramp up: final_value=0, cmd target=3, step_div=0 from duty=0 -> duty steps 1,2,3 at period_ends 1-3 (every 16 cycles); done is one cycle after the third step; busy is high throughout.
REQ-038 Scenario ramp down: from duty=3, cmd target=1, step_div=1 -> duty 2 after 2 periods and duty 1 after 4 periods; done pulses once.
REQ-039 Scenario abort: abort during a ramp 0->10 at duty=4, asserted in a period_end cycle -> duty stays 4, IDLE, no done, cmd_ready=1 next cycle.
REQ-040 Scenario equal/busy: cmd target==duty -> done next cycle, with no RAMP; cmd_valid during RAMP -> ignored, and the original target is reached.
REQ-041 Scenario reset/enable: enable=0 for 20 cycles mid-ramp -> counters and duty frozen; rst_n low mid-ramp -> all outputs reset immediately, without waiting for clk.
